// File: rtl/msg_defs.vh
`ifndef MSG_DEFS_VH
`define MSG_DEFS_VH
`define MARKER_MASTER            8'hA5
`define FLAG_TIME_MARK           8'h01
`define FLAG_STATUS_REQUEST      8'h02
`define FLAG_DATA_PACKET_REQUEST 8'h03
`endif

// File: rtl/msg_rx_ctrl.sv
// Message receiver: marker / flag / payload framing with an inter-byte timeout.
// Latency: result pulses 1 cycle after the deciding byte or timeout; no backpressure, every d_rdy byte is consumed.
`include "msg_defs.vh"

module msg_rx_ctrl #(
    parameter int TIMEOUT     = 1024,
    parameter int PAYLOAD_LEN = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               d,
    input  logic                     d_rdy,
    output logic                     tm_rcvd,
    output logic                     sr_rcvd,
    output logic                     dpr_rcvd,
    output logic [8*PAYLOAD_LEN-1:0] payload,
    output logic                     msg_err,
    output logic                     rx_busy
);

    localparam int CW = $clog2(PAYLOAD_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = 8 * PAYLOAD_LEN;

    typedef enum logic [1:0] {IDLE, FLAG, PAYLOAD} state_t;
    typedef enum logic [1:0] {TYP_TM, TYP_SR, TYP_DPR} typ_t;

    state_t          state, state_nxt;
    typ_t            typ;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tcnt;
    logic [PW-1:0]   shreg;
    logic [PW+7:0]   shift_full;
    logic [PW-1:0]   shreg_nxt;
    logic            flag_ok;
    logic            tout;
    logic            flag_take;
    logic            byte_take;
    logic            done;
    logic            err_nxt;

    assign shift_full = {shreg, d};
    assign shreg_nxt  = shift_full[PW-1:0];
    assign flag_ok    = (d == `FLAG_TIME_MARK) || (d == `FLAG_STATUS_REQUEST) ||
                        (d == `FLAG_DATA_PACKET_REQUEST);
    // An arriving byte always beats an expiring timeout.
    assign tout       = (state != IDLE) && !d_rdy && (tcnt == TW'(TIMEOUT - 1));
    assign rx_busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        done      = 1'b0;
        flag_take = 1'b0;
        byte_take = 1'b0;
        case (state)
            IDLE: begin
                if (d_rdy && d == `MARKER_MASTER) state_nxt = FLAG;
            end
            FLAG: begin
                if (d_rdy) begin
                    if (flag_ok) begin
                        flag_take = 1'b1;
                        state_nxt = PAYLOAD;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tout) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PAYLOAD: begin
                if (d_rdy) begin
                    byte_take = 1'b1;
                    if (cnt == CW'(PAYLOAD_LEN - 1)) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tout) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            typ      <= TYP_TM;
            cnt      <= '0;
            tcnt     <= '0;
            shreg    <= '0;
            payload  <= '0;
            msg_err  <= 1'b0;
            tm_rcvd  <= 1'b0;
            sr_rcvd  <= 1'b0;
            dpr_rcvd <= 1'b0;
        end else begin
            state    <= state_nxt;
            msg_err  <= err_nxt;
            tm_rcvd  <= done && (typ == TYP_TM);
            sr_rcvd  <= done && (typ == TYP_SR);
            dpr_rcvd <= done && (typ == TYP_DPR);
            tcnt     <= (state == IDLE || d_rdy) ? '0 : tcnt + TW'(1);
            if (flag_take) begin
                cnt <= '0;
                if (d == `FLAG_TIME_MARK)           typ <= TYP_TM;
                else if (d == `FLAG_STATUS_REQUEST) typ <= TYP_SR;
                else                                typ <= TYP_DPR;
            end
            if (byte_take) begin
                shreg <= shreg_nxt;
                cnt   <= cnt + CW'(1);
            end
            // The shadow copy only moves when a whole message lands.
            if (done) payload <= shreg_nxt;
        end
    end

endmodule

// File: tb/tb_msg_rx_ctrl.sv
// Randomized and directed bench for msg_rx_ctrl against a queue-based message model.
`ifndef MARKER_MASTER
`include "msg_defs.vh"
`endif

module tb_msg_rx_ctrl;
    localparam int TO = 16;
    localparam int PL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    d = 8'h00;
    logic          d_rdy = 1'b0;
    logic          tm_rcvd, sr_rcvd, dpr_rcvd, msg_err, rx_busy;
    logic [8*PL-1:0] payload;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]      mq[$];
    int              gap = 0;
    logic            m_tm = 0, m_sr = 0, m_dpr = 0, m_err = 0;
    logic [8*PL-1:0] m_pay = '0;

    msg_rx_ctrl #(.TIMEOUT(TO), .PAYLOAD_LEN(PL)) dut (
        .clk(clk), .rst(rst), .d(d), .d_rdy(d_rdy),
        .tm_rcvd(tm_rcvd), .sr_rcvd(sr_rcvd), .dpr_rcvd(dpr_rcvd),
        .payload(payload), .msg_err(msg_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_flag(input logic [7:0] b);
        return b == `FLAG_TIME_MARK || b == `FLAG_STATUS_REQUEST || b == `FLAG_DATA_PACKET_REQUEST;
    endfunction

    task automatic model_step(input bit v, input logic [7:0] b);
        m_tm = 0; m_sr = 0; m_dpr = 0; m_err = 0;
        if (v) begin
            gap = 0;
            if (mq.size() == 0) begin
                if (b == `MARKER_MASTER) mq.push_back(b);
            end else if (mq.size() == 1) begin
                if (is_flag(b)) mq.push_back(b);
                else begin m_err = 1; mq.delete(); end
            end else begin
                mq.push_back(b);
                if (mq.size() == PL + 2) begin
                    for (int i = 2; i < PL + 2; i++) m_pay = {m_pay[8*PL-9:0], mq[i]};
                    if (mq[1] == `FLAG_TIME_MARK)           m_tm = 1;
                    else if (mq[1] == `FLAG_STATUS_REQUEST) m_sr = 1;
                    else                                    m_dpr = 1;
                    mq.delete();
                end
            end
        end else if (mq.size() != 0) begin
            gap++;
            if (gap == TO) begin
                m_err = 1;
                mq.delete();
                gap = 0;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".msg_err"},  32'(msg_err),  32'(m_err));
        chk({ctx, ".tm_rcvd"},  32'(tm_rcvd),  32'(m_tm));
        chk({ctx, ".sr_rcvd"},  32'(sr_rcvd),  32'(m_sr));
        chk({ctx, ".dpr_rcvd"}, 32'(dpr_rcvd), 32'(m_dpr));
        chk({ctx, ".payload"},  32'(payload),  32'(m_pay));
        chk({ctx, ".rx_busy"},  32'(rx_busy),  32'(mq.size() != 0));
    endtask

    task automatic cyc(input string ctx, input bit v, input logic [7:0] b);
        d_rdy = v;
        d     = v ? b : 8'($urandom);
        @(posedge clk);
        model_step(v, b);
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) cyc(ctx, 1'b0, 8'h00);
    endtask

    task automatic send_msg(input string ctx, input logic [7:0] flag,
                            input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
        cyc(ctx, 1'b1, `MARKER_MASTER);
        cyc(ctx, 1'b1, flag);
        cyc(ctx, 1'b1, p0);
        cyc(ctx, 1'b1, p1);
        cyc(ctx, 1'b1, p2);
    endtask

    task automatic model_reset();
        mq.delete();
        gap = 0;
        m_tm = 0; m_sr = 0; m_dpr = 0; m_err = 0;
        m_pay = '0;
    endtask

    task automatic do_reset(input string ctx);
        d_rdy = 1'b0;
        rst   = 1'b1;
        model_reset();
        #1;
        check_all({ctx, ".async"});
        @(posedge clk);
        #1;
        check_all({ctx, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] flags[3];
        flags[0] = `FLAG_TIME_MARK;
        flags[1] = `FLAG_STATUS_REQUEST;
        flags[2] = `FLAG_DATA_PACKET_REQUEST;

        #2;
        do_reset("reset");
        idle("post_reset", 2);

        send_msg("tm", `FLAG_TIME_MARK, 8'h11, 8'h22, 8'h33);
        chk("tm.payload_const", 32'(payload), 32'h112233);
        chk("tm.pulse_const", 32'(tm_rcvd), 32'd1);
        idle("tm_after", 2);

        cyc("junk", 1'b1, 8'h00);
        cyc("junk", 1'b1, 8'h55);
        send_msg("sr", `FLAG_STATUS_REQUEST, 8'h44, 8'h55, 8'h66);
        idle("sr_after", 1);

        cyc("badflag", 1'b1, `MARKER_MASTER);
        cyc("badflag", 1'b1, 8'hEE);
        chk("badflag.err_const", 32'(msg_err), 32'd1);
        chk("badflag.pay_const", 32'(payload), 32'h445566);
        idle("badflag_after", 1);

        cyc("tout", 1'b1, `MARKER_MASTER);
        cyc("tout", 1'b1, `FLAG_DATA_PACKET_REQUEST);
        cyc("tout", 1'b1, 8'h77);
        idle("tout_gap", TO);
        chk("tout.err_const", 32'(msg_err), 32'd1);
        idle("tout_after", 2);

        cyc("edge", 1'b1, `MARKER_MASTER);
        cyc("edge", 1'b1, `FLAG_DATA_PACKET_REQUEST);
        cyc("edge", 1'b1, 8'h01);
        idle("edge_gap", TO - 1);
        cyc("edge", 1'b1, 8'h02);
        chk("edge.no_err", 32'(msg_err), 32'd0);
        cyc("edge", 1'b1, 8'h03);
        chk("edge.dpr_const", 32'(dpr_rcvd), 32'd1);
        chk("edge.pay_const", 32'(payload), 32'h010203);

        send_msg("b2b1", `FLAG_DATA_PACKET_REQUEST, 8'hA1, 8'hA2, 8'hA3);
        send_msg("b2b2", `FLAG_DATA_PACKET_REQUEST, `MARKER_MASTER, 8'hB2, 8'hB3);
        chk("b2b.pay_const", 32'(payload), {8'h00, `MARKER_MASTER, 16'hB2B3});
        idle("b2b_after", 1);

        cyc("midrst", 1'b1, `MARKER_MASTER);
        cyc("midrst", 1'b1, `FLAG_TIME_MARK);
        cyc("midrst", 1'b1, 8'hC1);
        #2;
        do_reset("midrst");
        send_msg("midrst_tm", `FLAG_TIME_MARK, 8'hD1, 8'hD2, 8'hD3);
        chk("midrst.pay_const", 32'(payload), 32'hD1D2D3);
        idle("midrst_after", 1);

        for (int n = 0; n < 3000; n++) begin
            int r;
            int s;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                idle("rand_gap", $urandom_range(TO - 2, TO + 1));
            end else begin
                s = $urandom_range(0, 9);
                if (s < 3)       b = `MARKER_MASTER;
                else if (s < 6)  b = flags[$urandom_range(0, 2)];
                else if (s == 6) b = 8'hEE;
                else             b = 8'($urandom);
                cyc("rand", r < 75, b);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
